// File: rtl/axis_master.sv
// ---------------------------------------------------------------------------
// axis_master
//
// AXI4-Stream transmit end. User logic enqueues bytes into an internal
// first-word-fall-through FIFO. A start command with a packet length then
// streams exactly that many beats on m_axis_*. tlast marks the final beat,
// and tready backpressure is honoured. Bytes beyond the packet length stay
// queued for the next packet.
//
// Ports
//   m_axis_aclk    in   clock, all logic on the rising edge
//   m_axis_arstn   in   synchronous active-low reset
//   data_in        in   byte to enqueue
//   wr_en          in   enqueue strobe (dropped while full)
//   full           out  FIFO holds FIFO_DEPTH entries
//   start          in   packet start request (accepted in IDLE, pkt_len != 0)
//   pkt_len        in   beats in the packet, sampled when start is accepted
//   busy           out  packet in progress
//   done           out  one-cycle pulse after the tlast beat transfers
//   m_axis_tdata   out  stream data (0 when tvalid is low)
//   m_axis_tvalid  out  stream valid
//   m_axis_tlast   out  last beat of the packet
//   m_axis_tready  in   downstream ready
// ---------------------------------------------------------------------------
module axis_master #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  m_axis_aclk,
  input  logic                  m_axis_arstn,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  wr_en,
  output logic                  full,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  pkt_len,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [LEN_WIDTH-1:0]  remaining_q, remaining_d;
  logic                  done_q, done_d;

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

  logic                  empty;
  logic                  wr_fire;
  logic                  pop;

  // Every output comes from registered state only. tvalid therefore never
  // depends on tready, and tdata/tlast cannot move while a beat is stalled.
  always_comb begin
    empty         = (count_q == '0);
    full          = (count_q == CNT_W'(FIFO_DEPTH));
    busy          = (state_q == SEND);
    done          = done_q;
    m_axis_tvalid = (state_q == SEND) && !empty;
    m_axis_tlast  = m_axis_tvalid && (remaining_q == LEN_WIDTH'(1));
    m_axis_tdata  = m_axis_tvalid ? mem_q[rd_ptr_q] : '0;
    wr_fire       = wr_en && !full;
    pop           = m_axis_tvalid && m_axis_tready;
  end

  // Next-state logic.
  // NOTE: every signal gets a default at the top so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    remaining_d = remaining_q;
    done_d      = 1'b0;

    // Pointers are PTR_W bits wide over a power-of-two depth, so the
    // increment wraps modulo FIFO_DEPTH.
    if (wr_fire) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)     rd_ptr_d = rd_ptr_q + PTR_W'(1);

    // A simultaneous write and pop leaves the count unchanged.
    unique case ({wr_fire, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    unique case (state_q)
      IDLE: begin
        if (start && (pkt_len != '0)) begin
          state_d     = SEND;
          remaining_d = pkt_len;
        end
      end
      SEND: begin
        // start is deliberately not looked at here.
        if (pop) begin
          remaining_d = remaining_q - LEN_WIDTH'(1);
          if (remaining_q == LEN_WIDTH'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its _d value from before the edge, whatever the statement order.
  always_ff @(posedge m_axis_aclk) begin
    if (!m_axis_arstn) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      remaining_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      remaining_q <= remaining_d;
      done_q      <= done_d;
    end
  end

  // NOTE: the storage array has no reset. Clearing the pointers and the
  // count already makes its contents unreachable, and a reset would stop
  // the array from mapping onto plain RAM.
  always_ff @(posedge m_axis_aclk) begin
    if (wr_fire) mem_q[wr_ptr_q] <= data_in;
  end

endmodule

// File: tb/tb_axis_master.sv
module tb_axis_master;

  logic       clk;
  logic       rst_n;
  logic [7:0] data_in;
  logic       wr_en;
  logic       full;
  logic       start;
  logic [7:0] pkt_len;
  logic       busy;
  logic       done;
  logic [7:0] tdata;
  logic       tvalid;
  logic       tlast;
  logic       tready;

  int n_checks = 0;
  int n_errors = 0;

  axis_master #(
    .DATA_WIDTH(8),
    .FIFO_DEPTH(16),
    .LEN_WIDTH (8)
  ) dut (
    .m_axis_aclk  (clk),
    .m_axis_arstn (rst_n),
    .data_in      (data_in),
    .wr_en        (wr_en),
    .full         (full),
    .start        (start),
    .pkt_len      (pkt_len),
    .busy         (busy),
    .done         (done),
    .m_axis_tdata (tdata),
    .m_axis_tvalid(tvalid),
    .m_axis_tlast (tlast),
    .m_axis_tready(tready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One row = inputs driven during a cycle plus the outputs expected during
  // that same cycle (the result of all earlier edges).
  typedef struct {
    logic       wr;
    logic [7:0] din;
    logic       st;
    logic [7:0] len;
    logic       rdy;
    logic       e_valid;
    logic [7:0] e_data;
    logic       e_last;
    logic       e_busy;
    logic       e_done;
    logic       e_full;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic wr, input logic [7:0] din, input logic st,
                     input logic [7:0] len, input logic rdy,
                     input logic ev, input logic [7:0] ed, input logic el,
                     input logic eb, input logic edn, input logic ef);
    vec_t v;
    v.wr = wr; v.din = din; v.st = st; v.len = len; v.rdy = rdy;
    v.e_valid = ev; v.e_data = ed; v.e_last = el;
    v.e_busy = eb; v.e_done = edn; v.e_full = ef;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic expect_out(input string name, input logic v,
                            input logic [7:0] d, input logic l,
                            input logic b, input logic dn);
    check({name, ".tvalid"}, 32'(tvalid), 32'(v));
    check({name, ".tdata"},  32'(tdata),  32'(d));
    check({name, ".tlast"},  32'(tlast),  32'(l));
    check({name, ".busy"},   32'(busy),   32'(b));
    check({name, ".done"},   32'(done),   32'(dn));
  endtask

  // Advance one cycle; inputs are driven and outputs sampled at negedge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    wr_en = 1'b0; data_in = 8'h00; start = 1'b0; pkt_len = 8'h00;
  endtask

  initial begin
    rst_n = 1'b0; tready = 1'b0;
    idle_inputs();
    @(negedge clk);
    step();
    rst_n = 1'b1;
    expect_out("reset", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    check("reset.full", 32'(full), 32'h0);

    // ---- basic packet, then the same packet under backpressure ----
    //  wr din   st len  rdy  v  data  l  b  d  f
    add(1, 8'h11, 0, 8'd0, 1, 0, 8'h00, 0, 0, 0, 0);
    add(1, 8'h22, 0, 8'd0, 1, 0, 8'h00, 0, 0, 0, 0);
    add(1, 8'h33, 0, 8'd0, 1, 0, 8'h00, 0, 0, 0, 0);
    add(1, 8'h44, 0, 8'd0, 1, 0, 8'h00, 0, 0, 0, 0);
    add(0, 8'h00, 1, 8'd4, 1, 0, 8'h00, 0, 0, 0, 0);
    add(0, 8'h00, 0, 8'd0, 1, 1, 8'h11, 0, 1, 0, 0);
    add(0, 8'h00, 0, 8'd0, 1, 1, 8'h22, 0, 1, 0, 0);
    add(0, 8'h00, 0, 8'd0, 1, 1, 8'h33, 0, 1, 0, 0);
    add(0, 8'h00, 0, 8'd0, 1, 1, 8'h44, 1, 1, 0, 0);
    add(0, 8'h00, 0, 8'd0, 1, 0, 8'h00, 0, 0, 1, 0);
    add(0, 8'h00, 0, 8'd0, 1, 0, 8'h00, 0, 0, 0, 0);
    add(1, 8'h11, 0, 8'd0, 1, 0, 8'h00, 0, 0, 0, 0);
    add(1, 8'h22, 0, 8'd0, 1, 0, 8'h00, 0, 0, 0, 0);
    add(1, 8'h33, 0, 8'd0, 1, 0, 8'h00, 0, 0, 0, 0);
    add(1, 8'h44, 0, 8'd0, 1, 0, 8'h00, 0, 0, 0, 0);
    add(0, 8'h00, 1, 8'd4, 1, 0, 8'h00, 0, 0, 0, 0);
    add(0, 8'h00, 0, 8'd0, 1, 1, 8'h11, 0, 1, 0, 0);
    add(0, 8'h00, 0, 8'd0, 0, 1, 8'h22, 0, 1, 0, 0);
    add(0, 8'h00, 0, 8'd0, 0, 1, 8'h22, 0, 1, 0, 0);
    add(0, 8'h00, 0, 8'd0, 1, 1, 8'h22, 0, 1, 0, 0);
    add(0, 8'h00, 0, 8'd0, 0, 1, 8'h33, 0, 1, 0, 0);
    add(0, 8'h00, 0, 8'd0, 1, 1, 8'h33, 0, 1, 0, 0);
    add(0, 8'h00, 0, 8'd0, 1, 1, 8'h44, 1, 1, 0, 0);
    add(0, 8'h00, 0, 8'd0, 1, 0, 8'h00, 0, 0, 1, 0);
    add(0, 8'h00, 0, 8'd0, 1, 0, 8'h00, 0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      wr_en = vecs[i].wr; data_in = vecs[i].din;
      start = vecs[i].st; pkt_len = vecs[i].len; tready = vecs[i].rdy;
      expect_out($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_data,
                 vecs[i].e_last, vecs[i].e_busy, vecs[i].e_done);
      check($sformatf("vec%0d.full", i), 32'(full), 32'(vecs[i].e_full));
      step();
    end
    idle_inputs();

    // ---- underrun: start with an empty FIFO ----
    start = 1'b1; pkt_len = 8'd3; tready = 1'b1;
    step();
    idle_inputs();
    expect_out("urun.n1", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    step();
    expect_out("urun.n2", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    step();
    wr_en = 1'b1; data_in = 8'hA0;
    expect_out("urun.n3", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    step();
    data_in = 8'hA1;
    expect_out("urun.a0", 1'b1, 8'hA0, 1'b0, 1'b1, 1'b0);
    step();
    data_in = 8'hA2;
    expect_out("urun.a1", 1'b1, 8'hA1, 1'b0, 1'b1, 1'b0);
    step();
    idle_inputs();
    expect_out("urun.a2", 1'b1, 8'hA2, 1'b1, 1'b1, 1'b0);
    step();
    expect_out("urun.done", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    step();

    // ---- fill to full; the 17th write is dropped ----
    for (int i = 0; i < 17; i++) begin
      wr_en = 1'b1; data_in = 8'(i);
      check($sformatf("fill%0d.full", i), 32'(full), (i == 16) ? 32'h1 : 32'h0);
      step();
    end
    idle_inputs();
    check("fill.full_hold", 32'(full), 32'h1);
    start = 1'b1; pkt_len = 8'd16; tready = 1'b0;
    step();
    start = 1'b0;
    expect_out("full.b0", 1'b1, 8'h00, 1'b0, 1'b1, 1'b0);
    check("full.b0.full", 32'(full), 32'h1);
    // Write while full (dropped) and pop in the same cycle.
    wr_en = 1'b1; data_in = 8'h55; tready = 1'b1;
    step();
    // full has dropped: this write lands alongside a pop.
    data_in = 8'h66;
    expect_out("full.b1", 1'b1, 8'h01, 1'b0, 1'b1, 1'b0);
    check("full.b1.full", 32'(full), 32'h0);
    step();
    idle_inputs();
    for (int i = 2; i < 16; i++) begin
      expect_out($sformatf("full.b%0d", i), 1'b1, 8'(i), (i == 15), 1'b1, 1'b0);
      step();
    end
    expect_out("full.done", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    step();

    // ---- ignored commands; FIFO now holds 0x66 ----
    start = 1'b1; pkt_len = 8'd0;
    step();
    start = 1'b0;
    expect_out("len0", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    wr_en = 1'b1; data_in = 8'h70;
    step();
    data_in = 8'h71;
    step();
    idle_inputs();
    start = 1'b1; pkt_len = 8'd2; tready = 1'b0;
    step();
    pkt_len = 8'd5;  // start during SEND must not reload the count
    expect_out("ign.hold", 1'b1, 8'h66, 1'b0, 1'b1, 1'b0);
    step();
    idle_inputs(); tready = 1'b1;
    expect_out("ign.b0", 1'b1, 8'h66, 1'b0, 1'b1, 1'b0);
    step();
    expect_out("ign.b1", 1'b1, 8'h70, 1'b1, 1'b1, 1'b0);
    step();
    expect_out("ign.done", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    start = 1'b1; pkt_len = 8'd1;  // accepted in the done cycle
    step();
    idle_inputs();
    expect_out("left.b0", 1'b1, 8'h71, 1'b1, 1'b1, 1'b0);
    step();
    expect_out("left.done", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    step();

    // ---- reset during the 2nd beat of 4 ----
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; data_in = 8'hB0 + 8'(i);
      step();
    end
    idle_inputs();
    start = 1'b1; pkt_len = 8'd4; tready = 1'b1;
    step();
    start = 1'b0;
    expect_out("rst.b0", 1'b1, 8'hB0, 1'b0, 1'b1, 1'b0);
    step();
    expect_out("rst.b1", 1'b1, 8'hB1, 1'b0, 1'b1, 1'b0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    expect_out("rst.after", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    check("rst.after.full", 32'(full), 32'h0);
    wr_en = 1'b1; data_in = 8'hC0;
    step();
    data_in = 8'hC1;
    step();
    idle_inputs();
    start = 1'b1; pkt_len = 8'd2;
    step();
    start = 1'b0;
    expect_out("post.b0", 1'b1, 8'hC0, 1'b0, 1'b1, 1'b0);
    step();
    expect_out("post.b1", 1'b1, 8'hC1, 1'b1, 1'b1, 1'b0);
    step();
    expect_out("post.done", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    step();
    expect_out("post.idle", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/axis_master.md
Name: axis_master

Overview:
- AXI4-Stream master (transmit end) for the axi_stream block; pairs with the team's AXIS slave on the same 8-bit stream.
- User logic pushes bytes into an internal FWFT FIFO, then issues a start command with a packet length.
- The block streams exactly that many bytes on m_axis_*, asserts tlast on the final beat and honours tready backpressure.

Parameters:
- DATA_WIDTH, 8, width of data_in and m_axis_tdata.
- FIFO_DEPTH, 16, FIFO entries; power of 2, ≥2.
- LEN_WIDTH, 8, width of pkt_len and the internal remaining-beat counter.

Ports:
- m_axis_aclk  input  1  clock; all logic on its rising edge.
- m_axis_arstn  input  1  synchronous active-low reset.
- data_in  input  DATA_WIDTH  byte to enqueue.
- wr_en  input  1  enqueue strobe.
- full  output  1  FIFO holds FIFO_DEPTH entries.
- start  input  1  packet start request.
- pkt_len  input  LEN_WIDTH  beats in the packet; sampled when start is accepted.
- busy  output  1  packet in progress (state SEND).
- done  output  1  one-cycle pulse after the tlast beat transfers.
- m_axis_tdata  output  DATA_WIDTH  stream data.
- m_axis_tvalid  output  1  stream valid.
- m_axis_tlast  output  1  last beat of packet.
- m_axis_tready  input  1  downstream ready.

Behaviour:
- Reset (m_axis_arstn low at a clock edge):
  - State IDLE; FIFO pointers and count cleared (contents discarded).
  - Remaining counter 0.
  - full, busy, done, m_axis_tvalid, m_axis_tlast = 0; m_axis_tdata = 0.
  - Applies mid-packet: the stream aborts without tlast.
- FIFO:
  - Write when wr_en && !full; wr_en while full is dropped, with no state change.
  - FWFT: head entry drives m_axis_tdata. A byte written into an empty FIFO at edge N is visible from cycle N+1; there is no same-cycle bypass.
  - Pop only on a stream transfer (tvalid && tready).
  - Simultaneous write and pop: both occur and the count is unchanged. full deasserts the cycle after a pop.
  - Pointers wrap modulo FIFO_DEPTH.
  - full is derived from the registered count.
- States:
  - IDLE: busy=0, tvalid=0. start && pkt_len!=0 → SEND; remaining <= pkt_len. start with pkt_len==0 is ignored.
  - SEND: busy=1. start is ignored.
    - m_axis_tvalid = (FIFO not empty).
    - m_axis_tlast = tvalid && remaining==1.
    - m_axis_tdata = head when tvalid, else 0.
    - On each transfer: pop and remaining <= remaining-1.
    - Transfer with remaining==1 → IDLE; done=1 on the next cycle only.
- AXIS compliance:
  - tvalid never depends combinationally on tready.
  - Once tvalid=1, tdata and tlast hold stable until the transfer, because the head changes only on pop and remaining changes only on transfer.
  - tvalid drops only after a transfer, when the FIFO becomes empty (underrun pause mid-packet is allowed), or on reset.
- Latency: start accepted at edge N with the FIFO non-empty → tvalid=1 during cycle N+1. Full-rate streaming at 1 beat/cycle while tready=1 and the FIFO is non-empty.
- Bytes beyond pkt_len remain in the FIFO for the next packet.
- Back-to-back packets: start can be accepted in the IDLE cycle in which done=1. That gives one idle cycle minimum between packets.
- pkt_len max 2^LEN_WIDTH-1; no wrap on the remaining counter.

Test Plan:
- Basic packet: write 0x11,0x22,0x33,0x44; start with pkt_len=4, tready=1.
  - Required: tdata 0x11..0x44 on 4 consecutive cycles starting one cycle after start.
  - tlast only with 0x44; done pulses 1 cycle later; busy=0 after.
- Backpressure: same packet, tready toggling 1,0,0,1,0,1,1.
  - Required: tvalid held; tdata/tlast stable through every tready=0 cycle; exactly 4 transfers; tlast on the 4th.
- Underrun: start pkt_len=3 with the FIFO empty; write 0xA0 three cycles later, then 0xA1,0xA2.
  - Required: tvalid=0 until the cycle after the first write; packet completes with tlast on 0xA2.
- Full/overflow: write 17 bytes 0x00..0x10 with DATA_WIDTH=8, FIFO_DEPTH=16.
  - Required: full=1 after the 16th write; 0x10 dropped; a 16-beat packet emits 0x00..0x0F.
  - Then simultaneous write+pop at full: write accepted after full drops, order preserved.
- Ignored commands: start with pkt_len=0 → busy stays 0. start during SEND → no effect on the remaining count; excess bytes stay queued.
- Reset mid-packet: arstn low during the 2nd beat of 4.
  - Required: next cycle tvalid=0, tlast=0, tdata=0, busy=0, full=0.
  - New 2-byte packet afterwards streams correctly from fresh writes.
